sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
// Shares the single byte-wide SDRAM controller port between three requesters:
// port 0 (ROM/ioctl download), port 1 (CPU) and port 2 (video/aux).
// Generates the controller's clkref slot reference and presents one access
// per slot. Returns read data and a one-cycle ack to the owning requester.
// Guarantees idle slots so the controller can issue auto-refresh.
// PARAMETERS
// SLOT_CYCLES  6   clk cycles per access slot; must equal the controller cycle length
// REFRESH_MAX  8   max consecutive granted slots before one slot is forced idle
// ADDR_W       25  byte address width
// PORTS
// clk        in   1       controller clock, same clock as the SDRAM controller
// reset_n    in   1       synchronous, active-low reset
// pN_req     in   1       (N=0..2) access request, level; held until pN_ack
// pN_we      in   1       1=write, 0=read; stable while pN_req is high
// pN_addr    in   ADDR_W  byte address; stable while pN_req is high
// pN_din     in   8       write data; stable while pN_req is high
// pN_ack     out  1       one-cycle pulse: access complete (pN_dout valid on reads)
// pN_dout    out  8       read data; held until the next read completes on that port
// clkref     out  1       slot reference to controller; registered, 1 in slots 0..2
// ram_addr   out  ADDR_W  address to controller, registered
// ram_din    out  8       write data to controller, registered
// ram_oe     out  1       read request to controller, registered
// ram_we     out  1       write request to controller, registered
// ram_dout   in   8       read data from controller
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): slot=0, clkref=0, ram_oe=ram_we=0, ram_addr=0,
//   ram_din=0, all pN_ack=0, all pN_dout=0, rr pointer=port 1, inflight cleared,
//   burst count=0. An access in flight at reset is abandoned; no ack is issued.
// - slot counter: 0..SLOT_CYCLES-1, wraps to 0. clkref = (slot<3), registered.
//   Controller phase 0 therefore coincides with arbiter slot 0.
// - Grant: decided on the 5->0 transition. Outputs ram_* are registered then and
//   held unchanged for the entire slot (all SLOT_CYCLES cycles).
// - Eligible = req high AND not the port granted in the previous slot (its ack
//   is still pending). Port 0 has fixed priority. Ports 1/2 are round-robin:
//   after port 1 or 2 is granted, the rr pointer moves to the other one.
// - No eligible port, or burst count==REFRESH_MAX: ram_oe=ram_we=0 for the slot
//   (controller refreshes). Burst count is then cleared. Each granted slot
//   increments burst count, saturating at REFRESH_MAX.
// - Granted read: ram_oe=1, ram_we=0. Granted write: ram_we=1, ram_oe=0,
//   ram_din=pN_din. Never both 1.
// - Completion: the access granted in slot N completes in slot N+1. At the
//   slot-0 cycle of N+1, latch ram_dout into pN_dout (reads only). pN_ack pulses
//   in slot 1 of N+1. Latency: grant-to-ack = SLOT_CYCLES+1 clk.
// - Requester drops req on or after ack. If req is still high in the cycle after
//   ack, it is a new access, eligible from the following grant.
// - Simultaneous requests from all ports: port 0 wins every eligible slot.
//   Ports 1/2 are served only in slots where port 0 is ineligible (in-flight mask),
//   i.e. at least every second slot.
// - Request withdrawn before grant: ignored, no ack. Request changes after grant
//   do not affect the latched ram_* values.
// TESTING
// - Reset mid-slot with p1 read in flight -> no p1_ack. ram_oe=ram_we=0.
//   First clkref rise occurs 1 clk after reset_n=1.
// - p1 read addr 0x000123, ram model returns 0xA5 -> ram_oe=1 in slot 0.
//   p1_ack in slot 1 of next slot (7 clk after grant), p1_dout=0xA5.
// - p1 and p2 reads held continuously -> grants alternate 1,2,1,2. No port is
//   granted in two consecutive slots. Each ack arrives exactly once per access.
// - p0 writes held continuously with 0x5A -> grants p0 at most every second slot.
//   ram_we=1, ram_din=0x5A. p1 is granted in the gaps.
// - All three ports held for 20 slots -> after 8 granted slots there is exactly
//   one slot with ram_oe=ram_we=0. ram_oe and ram_we are never both high.
// - p2 req pulsed for 2 clk before slot 0 then dropped -> p2 is not granted and
//   no p2_ack is issued.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of a byte-wide SDRAM controller: one access per
// slot, port 0 fixed priority, ports 1/2 round-robin, forced idle slots for refresh.
module sdram_arbiter #(
    parameter int SLOT_CYCLES = 6,
    parameter int REFRESH_MAX = 8,
    parameter int ADDR_W      = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_din,
    output logic              p0_ack,
    output logic [7:0]        p0_dout,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_din,
    output logic              p1_ack,
    output logic [7:0]        p1_dout,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [7:0]        p2_din,
    output logic              p2_ack,
    output logic [7:0]        p2_dout,
    output logic              clkref,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_oe,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);
    localparam int SLOT_W  = $clog2(SLOT_CYCLES);
    localparam int BURST_W = $clog2(REFRESH_MAX + 1);

    typedef enum logic [1:0] {PORT0 = 2'd0, PORT1 = 2'd1, PORT2 = 2'd2} port_t;

    typedef struct packed {
        logic  valid;
        port_t port;
        logic  we;
    } access_t;

    logic [SLOT_W-1:0]  slot;
    logic [SLOT_W-1:0]  slot_next;
    logic               slot_last;
    logic [BURST_W-1:0] burst;
    logic               rr_p2;
    access_t            cur;
    access_t            done;
    logic [2:0]         ack;
    logic [2:0]         elig;

    logic               grant_valid;
    port_t              grant_port;
    logic               grant_we;
    logic [ADDR_W-1:0]  grant_addr;
    logic [7:0]         grant_din;

    assign slot_last = (slot == SLOT_W'(SLOT_CYCLES - 1));
    assign slot_next = slot_last ? '0 : slot + SLOT_W'(1);

    // The port owning the current slot still awaits its ack, so it sits out the next grant.
    always_comb begin
        elig[0] = p0_req && !(cur.valid && cur.port == PORT0);
        elig[1] = p1_req && !(cur.valid && cur.port == PORT1);
        elig[2] = p2_req && !(cur.valid && cur.port == PORT2);
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT0;
        if (burst != BURST_W'(REFRESH_MAX)) begin
            if (elig[0]) begin
                grant_valid = 1'b1;
                grant_port  = PORT0;
            end else if (elig[1] && (!elig[2] || !rr_p2)) begin
                grant_valid = 1'b1;
                grant_port  = PORT1;
            end else if (elig[2]) begin
                grant_valid = 1'b1;
                grant_port  = PORT2;
            end
        end
    end

    always_comb begin
        grant_we   = p0_we;
        grant_addr = p0_addr;
        grant_din  = p0_din;
        case (grant_port)
            PORT1: begin
                grant_we   = p1_we;
                grant_addr = p1_addr;
                grant_din  = p1_din;
            end
            PORT2: begin
                grant_we   = p2_we;
                grant_addr = p2_addr;
                grant_din  = p2_din;
            end
            default: ;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot     <= '0;
            clkref   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_oe   <= 1'b0;
            ram_we   <= 1'b0;
            burst    <= '0;
            rr_p2    <= 1'b0;
            cur      <= '0;
            done     <= '0;
            ack      <= '0;
            p0_dout  <= '0;
            p1_dout  <= '0;
            p2_dout  <= '0;
        end else begin
            slot   <= slot_next;
            clkref <= (slot_next < SLOT_W'(3));
            ack    <= '0;

            if (slot_last) begin
                done   <= cur;
                cur    <= '{valid: grant_valid, port: grant_port, we: grant_we};
                ram_oe <= grant_valid && !grant_we;
                ram_we <= grant_valid && grant_we;
                if (grant_valid) begin
                    ram_addr <= grant_addr;
                    if (grant_we) ram_din <= grant_din;
                    burst <= burst + BURST_W'(1);
                    if (grant_port == PORT1) rr_p2 <= 1'b1;
                    else if (grant_port == PORT2) rr_p2 <= 1'b0;
                end else begin
                    burst <= '0;
                end
            end

            // Previous slot's access completes: capture read data, then ack one cycle later.
            if (slot == '0 && done.valid) begin
                done.valid <= 1'b0;
                case (done.port)
                    PORT0: begin
                        ack[0] <= 1'b1;
                        if (!done.we) p0_dout <= ram_dout;
                    end
                    PORT1: begin
                        ack[1] <= 1'b1;
                        if (!done.we) p1_dout <= ram_dout;
                    end
                    PORT2: begin
                        ack[2] <= 1'b1;
                        if (!done.we) p2_dout <= ram_dout;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign p0_ack = ack[0];
    assign p1_ack = ack[1];
    assign p2_ack = ack[2];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: slot-by-slot vector table plus hand-written
// sequences for reset, latency and withdrawn requests.
module tb_sdram_arbiter;
    localparam int ADDR_W = 25;
    localparam logic [ADDR_W-1:0] A0 = 25'h1F00010;
    localparam logic [ADDR_W-1:0] A1 = 25'h0000123;
    localparam logic [ADDR_W-1:0] A2 = 25'h00ABCDE;
    localparam logic [7:0] D0 = 8'h5A;
    localparam logic [7:0] D1 = 8'h11;
    localparam logic [7:0] D2 = 8'h77;
    localparam int NVEC = 38;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic p0_req = 1'b0, p0_we = 1'b0, p0_ack;
    logic p1_req = 1'b0, p1_we = 1'b0, p1_ack;
    logic p2_req = 1'b0, p2_we = 1'b0, p2_ack;
    logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0, p2_addr = '0;
    logic [7:0] p0_din = '0, p1_din = '0, p2_din = '0;
    logic [7:0] p0_dout, p1_dout, p2_dout;
    logic clkref, ram_oe, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = '0;

    int phase = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] we;
        int         gnt;   // 0..2 granted port, 3 idle
    } vec_t;

    vec_t tbl[NVEC];

    always #5 clk = ~clk;

    sdram_arbiter #(.SLOT_CYCLES(6), .REFRESH_MAX(8), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_ack(p1_ack), .p1_dout(p1_dout),
        .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_din(p2_din),
        .p2_ack(p2_ack), .p2_dout(p2_dout),
        .clkref(clkref), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    function automatic logic [7:0] data_of(input logic [ADDR_W-1:0] a);
        return (a == A1) ? 8'hA5 : (a[7:0] ^ 8'h3C);
    endfunction

    // Expected slot position and a controller that returns read data mid-slot.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) phase <= 0;
        else phase <= (phase == 5) ? 0 : phase + 1;
    end

    always @(posedge clk) begin
        if (reset_n && phase == 3 && ram_oe) ram_dout <= data_of(ram_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int p);
        case (p)
            0: return A0;
            1: return A1;
            default: return A2;
        endcase
    endfunction

    function automatic logic [7:0] din_of(input int p);
        case (p)
            0: return D0;
            1: return D1;
            default: return D2;
        endcase
    endfunction

    function automatic logic [7:0] dout_of(input int p);
        case (p)
            0: return p0_dout;
            1: return p1_dout;
            default: return p2_dout;
        endcase
    endfunction

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] we, input int gnt);
        vec_t v;
        v.req = req;
        v.we  = we;
        v.gnt = gnt;
        return v;
    endfunction

    task automatic drive(input logic [2:0] req, input logic [2:0] we);
        p0_req = req[0]; p1_req = req[1]; p2_req = req[2];
        p0_we  = we[0];  p1_we  = we[1];  p2_we  = we[2];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(3'b000, 3'b001);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_phase(input int p);
        int found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (phase == p) begin
                found = 1;
                break;
            end
        end
        check("wait_phase", found, 1);
    endtask

    task automatic check_slot(input string tag, input int g, input logic [2:0] we);
        logic exp_w;
        exp_w = (g < 3) ? we[g] : 1'b0;
        check({tag, "_oe"}, ram_oe, (g < 3) && !exp_w);
        check({tag, "_we"}, ram_we, (g < 3) && exp_w);
        if (g < 3) begin
            check({tag, "_addr"}, ram_addr, addr_of(g));
            if (exp_w) check({tag, "_din"}, ram_din, din_of(g));
        end
    endtask

    initial begin
        int t0, t1, cnt_ack, cnt_oe, pg;
        logic [2:0] pwe, ea;

        p0_addr = A0; p1_addr = A1; p2_addr = A2;
        p0_din  = D0; p1_din  = D1; p2_din  = D2;

        // Slot table: {p2,p1,p0} requests, {p2,p1,p0} write flags, expected grant.
        tbl[0]  = mk(3'b110, 3'b001, 1);
        tbl[1]  = mk(3'b110, 3'b001, 2);
        tbl[2]  = mk(3'b110, 3'b001, 1);
        tbl[3]  = mk(3'b110, 3'b001, 2);
        tbl[4]  = mk(3'b100, 3'b001, 3);
        tbl[5]  = mk(3'b000, 3'b001, 3);
        tbl[6]  = mk(3'b011, 3'b001, 0);
        tbl[7]  = mk(3'b011, 3'b001, 1);
        tbl[8]  = mk(3'b011, 3'b001, 0);
        tbl[9]  = mk(3'b011, 3'b001, 1);
        tbl[10] = mk(3'b011, 3'b001, 0);
        tbl[11] = mk(3'b001, 3'b001, 3);
        tbl[12] = mk(3'b000, 3'b001, 3);
        begin
            int c_g[20] = '{0, 2, 0, 1, 0, 2, 0, 1, 3, 0, 2, 0, 1, 0, 2, 0, 1, 3, 0, 2};
            for (int i = 0; i < 20; i++) tbl[13 + i] = mk(3'b111, 3'b001, c_g[i]);
        end
        tbl[33] = mk(3'b100, 3'b001, 3);
        tbl[34] = mk(3'b000, 3'b001, 3);
        tbl[35] = mk(3'b100, 3'b101, 2);
        tbl[36] = mk(3'b100, 3'b101, 3);
        tbl[37] = mk(3'b000, 3'b001, 3);

        // Reset state and first clkref rise.
        repeat (3) @(negedge clk);
        check("rst_clkref", clkref, 0);
        check("rst_oe", ram_oe, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_din", ram_din, 0);
        check("rst_ack", {p2_ack, p1_ack, p0_ack}, 0);
        check("rst_dout", {p2_dout, p1_dout, p0_dout}, 0);
        reset_n = 1'b1;
        check("clkref_pre_rise", clkref, 0);
        @(negedge clk);
        check("clkref_rise", clkref, 1);

        // Single p1 read: grant in slot 0, ack 7 clk later with ram data.
        p1_we = 1'b0;
        p1_req = 1'b1;
        t0 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_oe) begin
                t0 = cyc;
                break;
            end
        end
        check("lat_grant_seen", t0 >= 0, 1);
        check("lat_grant_phase", phase, 0);
        check("lat_grant_we", ram_we, 0);
        check("lat_grant_addr", ram_addr, A1);
        t1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p1_ack) begin
                t1 = cyc;
                break;
            end
        end
        check("lat_ack_clk", t1 - t0, 7);
        check("lat_dout", p1_dout, 8'hA5);
        p1_req = 1'b0;
        @(negedge clk);
        check("lat_ack_pulse", p1_ack, 0);

        // Reset while a p1 read is in flight: the access is abandoned.
        p1_req = 1'b1;
        t0 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_oe) begin
                t0 = cyc;
                break;
            end
        end
        check("midrst_grant_seen", t0 >= 0, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        p1_req = 1'b0;
        cnt_ack = 0;
        repeat (2) begin
            @(negedge clk);
            if (p1_ack) cnt_ack++;
        end
        check("midrst_oe", ram_oe, 0);
        check("midrst_we", ram_we, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p1_ack) cnt_ack++;
        end
        check("midrst_no_ack", cnt_ack, 0);

        // p2 request pulsed for 2 clk before the grant edge, then dropped.
        do_reset();
        wait_phase(3);
        p2_we = 1'b0;
        p2_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        p2_req = 1'b0;
        cnt_ack = 0;
        cnt_oe = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (p2_ack) cnt_ack++;
            if (ram_oe || ram_we) cnt_oe++;
        end
        check("withdraw_no_grant", cnt_oe, 0);
        check("withdraw_no_ack", cnt_ack, 0);

        // Slot table, starting from the idle slot that follows reset.
        do_reset();
        wait_phase(2);
        pg = 3;
        pwe = 3'b001;
        for (int k = 0; k < NVEC; k++) begin
            drive(tbl[k].req, tbl[k].we);
            for (int j = 0; j < 6; j++) begin
                if (j > 0) @(negedge clk);
                if (j < 4) check_slot($sformatf("v%0d_prev", k), pg, pwe);
                else check_slot($sformatf("v%0d", k), tbl[k].gnt, tbl[k].we);
                check($sformatf("v%0d_clkref", k), clkref, phase < 3);
                ea = 3'b000;
                if (j == 5 && pg < 3) ea[pg] = 1'b1;
                check($sformatf("v%0d_ack_j%0d", k, j), {p2_ack, p1_ack, p0_ack}, ea);
                if (j == 5 && pg < 3 && !pwe[pg])
                    check($sformatf("v%0d_dout", k), dout_of(pg), data_of(addr_of(pg)));
            end
            pg = tbl[k].gnt;
            pwe = tbl[k].we;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
